// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg_pkg
//  Brief    : Shared types and constants for the 4-digit 7-segment scanner.
//  Revision : 1.0
// ============================================================================
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [3:0] c_an_off  = 4'b1111;

    // Digit idx is a leading zero when it and every digit above it are zero.
    function automatic logic is_leading_zero(input logic [15:0] val, input logic [1:0] idx);
        logic r;
        case (idx)
            2'd1:    r = (val[15:4]  == 12'h000);
            2'd2:    r = (val[15:8]  == 8'h00);
            2'd3:    r = (val[15:12] == 4'h0);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_to_seg7.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_to_seg7
//  Brief    : BCD nibble to active-low {g,f,e,d,c,b,a}; non-BCD shows a dash.
//  Revision : 1.0
// ============================================================================
module bcd_to_seg7
    import seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        case (i_nibble)
            4'd0:    o_seg = 7'b1000000;
            4'd1:    o_seg = 7'b1111001;
            4'd2:    o_seg = 7'b0100100;
            4'd3:    o_seg = 7'b0110000;
            4'd4:    o_seg = 7'b0011001;
            4'd5:    o_seg = 7'b0010010;
            4'd6:    o_seg = 7'b0000010;
            4'd7:    o_seg = 7'b1111000;
            4'd8:    o_seg = 7'b0000000;
            4'd9:    o_seg = 7'b0010000;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_ctrl
//  Brief    : Multiplexed 4-digit 7-segment scanner with blanking and LZ suppression.
//  Revision : 1.0
// ============================================================================
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int BLANK_CYC   = 4,
    parameter int LZ_SUPPRESS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scan_tick,
    input  logic        en,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam logic [7:0] c_blank_load = 8'(BLANK_CYC - 1);

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_idx,   w_idx_nxt;
    logic [7:0]  r_bcnt,  w_bcnt_nxt;
    logic [15:0] r_val,   w_val_nxt;
    logic [3:0]  r_dpm,   w_dpm_nxt;
    logic [3:0]  r_an,    w_an_nxt;
    logic [6:0]  r_seg,   w_seg_nxt;
    logic        r_dp,    w_dp_nxt;
    logic        w_fd;
    logic [3:0]  w_nib;
    logic [6:0]  w_dec;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= 2'd0;
            r_bcnt  <= 8'd0;
            r_val   <= 16'h0000;
            r_dpm   <= 4'h0;
            r_an    <= c_an_off;
            r_seg   <= SEG_BLANK;
            r_dp    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_val   <= w_val_nxt;
            r_dpm   <= w_dpm_nxt;
            r_an    <= w_an_nxt;
            r_seg   <= w_seg_nxt;
            r_dp    <= w_dp_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_bcnt_nxt  = r_bcnt;
        w_val_nxt   = r_val;
        w_dpm_nxt   = r_dpm;
        w_fd        = 1'b0;
        if (!en) begin
            w_state_nxt = IDLE;
            w_idx_nxt   = 2'd0;
            w_bcnt_nxt  = 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = SHOW;
                    w_idx_nxt   = 2'd0;
                    w_val_nxt   = value;
                    w_dpm_nxt   = dp_in;
                end
                SHOW: begin
                    if (scan_tick) begin
                        w_state_nxt = BLANK;
                        w_bcnt_nxt  = c_blank_load;
                        w_fd        = (r_idx == 2'd3);
                    end
                end
                BLANK: begin
                    if (r_bcnt == 8'd0) begin
                        w_state_nxt = SHOW;
                        w_idx_nxt   = r_idx + 2'd1;
                        // Frame boundary: new value is only sampled on the 3->0 wrap.
                        if (r_idx == 2'd3) begin
                            w_val_nxt = value;
                            w_dpm_nxt = dp_in;
                        end
                    end else begin
                        w_bcnt_nxt = r_bcnt - 8'd1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Outputs are registered from next-state values so they track the state edge exactly.
    always_comb begin
        case (w_idx_nxt)
            2'd0:    w_nib = w_val_nxt[3:0];
            2'd1:    w_nib = w_val_nxt[7:4];
            2'd2:    w_nib = w_val_nxt[11:8];
            default: w_nib = w_val_nxt[15:12];
        endcase
    end

    bcd_to_seg7 u_dec (
        .i_nibble (w_nib),
        .o_seg    (w_dec)
    );

    always_comb begin
        w_an_nxt  = c_an_off;
        w_seg_nxt = SEG_BLANK;
        w_dp_nxt  = 1'b1;
        if (w_state_nxt == SHOW) begin
            w_an_nxt  = ~(4'b0001 << w_idx_nxt);
            w_seg_nxt = ((LZ_SUPPRESS != 0) && is_leading_zero(w_val_nxt, w_idx_nxt))
                        ? SEG_BLANK : w_dec;
            w_dp_nxt  = ~w_dpm_nxt[w_idx_nxt];
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign frame_done = w_fd & ~rst;

endmodule
`default_nettype wire

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 The parameter BLANK_CYC SHALL default to 4 and set the inter-digit blanking length in clk cycles; legal values are 1..255.
REQ-002 The parameter LZ_SUPPRESS SHALL default to 1 and, when 1, enable leading-zero suppression.
REQ-003 Port clk, input, 1 bit: the single system clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port rst, input, 1 bit: the reset, which SHALL be synchronous and active-high.
REQ-005 Port scan_tick, input, 1 bit: a one-cycle strobe at the 1 kHz scan rate, synchronous to clk.
REQ-006 Port en, input, 1 bit: display enable.
REQ-007 Port value, input, 16 bits: four BCD digits; [3:0] is digit 0 (rightmost) and [15:12] is digit 3.
REQ-008 Port dp_in, input, 4 bits: decimal-point request per digit, active-high.
REQ-009 Port an, output, 4 bits: digit anodes, active-low, with an[i] selecting digit i.
REQ-010 Port seg, output, 7 bits: segments {g,f,e,d,c,b,a}, active-low.
REQ-011 Port dp, output, 1 bit: decimal point, active-low.
REQ-012 Port frame_done, output, 1 bit: a one-cycle pulse when digit 3's display slot ends.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHOW, BLANK.
REQ-014 IDLE -> SHOW SHALL occur on the first cycle with en=1; digit index=0; value and dp_in are latched into shadow registers in that same cycle.
REQ-015 SHOW with scan_tick=1 -> BLANK; the blank counter loads BLANK_CYC-1.
REQ-016 BLANK SHALL decrement each cycle.
REQ-017 When the blank counter is 0, BLANK -> SHOW and digit index increments modulo 4.
REQ-018 On the 3->0 wrap, shadow value/dp SHALL reload from the inputs in the same cycle.
REQ-019 frame_done SHALL pulse in the cycle of the SHOW->BLANK transition while digit index=3.
REQ-020 In SHOW, an SHALL be one-hot-low for the current digit, registered (one-cycle latency from the state change).
REQ-021 In SHOW, seg and dp SHALL come from the shadow registers, never directly from value/dp_in.
REQ-022 In BLANK and IDLE, an SHALL be 4'b1111, seg 7'h7F and dp 1.
REQ-023 scan_tick arriving in BLANK or IDLE SHALL be ignored (not queued).
REQ-024 Decoding SHALL use the standard digits 0-9, with 0=7'b1000000 and 8=7'b0000000.
REQ-025 Nibbles 10-15 SHALL display the dash 7'b0111111.
REQ-026 With LZ_SUPPRESS=1, a digit i in 1..3 SHALL be blanked (seg=7'h7F) when it and all higher digits are 0.
REQ-027 Digit 0 SHALL never be suppressed.
REQ-028 The anode for a suppressed digit SHALL still be driven low.
REQ-029 dp_in SHALL be honoured even on suppressed digits.
REQ-030 en=0 in any state SHALL force IDLE on the next edge; outputs go blank that same edge.
REQ-031 en=0 with a coincident scan_tick: en wins, and no frame_done is emitted.
REQ-032 Mid-frame changes on value SHALL be invisible until the next frame boundary.

Reset
REQ-033 With rst=1 at a clk edge, the state SHALL become IDLE; digit index 0; blank counter 0; shadow value 16'h0000, shadow dp 4'h0.
REQ-034 During reset, outputs SHALL be an=4'b1111, seg=7'h7F, dp=1, frame_done=0.
REQ-035 rst SHALL take priority over en and scan_tick.
REQ-036 Reset asserted mid-BLANK or mid-SHOW SHALL abort immediately with no pending frame_done.

Structure
REQ-037 Package seg_pkg SHALL hold the state enum (IDLE, SHOW, BLANK) and the constants SEG_BLANK=7'h7F and SEG_DASH=7'b0111111.
REQ-038 A combinational sub-module bcd_to_seg7 (4-bit nibble in, 7-bit active-low seg out, dash for >9) SHALL be instantiated once on the muxed nibble.
REQ-039 The blank counter SHALL be 8 bits; the digit index 2 bits.

Verification
REQ-040 rst 2 cycles, en=1, value=16'h1234, dp_in=0, BLANK_CYC=4, scan_tick every 20 cycles -> anodes cycle 1110,1101,1011,0111 with seg 0=7'b0011001(4), 1=7'b0110000(3), 2=7'b0100100(2), 3=7'b1111001(1); exactly 4 blank cycles of an=4'b1111 between digits.
REQ-041 value=16'h0050, LZ_SUPPRESS=1 -> digit 3 and digit 2 seg=7'h7F with anode low, digit 1 shows 5, digit 0 shows 0; value=16'h0000 -> only digit 0 shows 0.
REQ-042 value=16'h00A9 -> digit 1 shows the dash 7'b0111111, digit 0 shows 9 (7'b0010000).
REQ-043 value changes from 16'h1111 to 16'h2222 while digit 1 is shown -> digits 1..3 of that frame still show 1; first 2 appears on digit 0 after the wrap; frame_done pulsed once in between.
REQ-044 en dropped in the same cycle as scan_tick during SHOW of digit 3 -> next edge an=4'b1111, no frame_done; en=1 again -> restart at digit 0 with freshly latched value.
REQ-045 rst asserted on the 2nd cycle of BLANK -> next edge IDLE, all outputs blank, frame_done=0; scan_tick during IDLE produces no output change.
